hack_alu_pipe: RTL and testbench

Pipelined, width-parametrised successor to the Hack combinational ALU. It keeps the six Hack control bits (zx, nx, zy, ny, f, no) and the zr/ng flags. It registers the operation through two stages with valid/ready handshakes on input and output, and carries a user tag alongside each operation. It sits between the CPU decode stage and writeback, so the ALU can be retimed off the critical path without changing Hack semantics.

---
 rtl/hack_alu_pipe.sv | 95 +++++++++
 tb/tb_hack_alu_pipe.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/hack_alu_pipe.sv
// hack_alu_pipe: two-stage pipelined Hack ALU with valid/ready handshakes and a tag carried with each operation.
// Ports: i_Clk/i_Rst_n clock and async active-low reset; i_InValid/o_InReady input handshake;
//   i_Data1/i_Data2 x/y operands; i_Ctrl {zx,nx,zy,ny,f,no}; i_Tag operation tag;
//   o_OutValid/i_OutReady output handshake; o_Result, o_zr, o_ng, o_cy, o_ov, o_Tag result and flags.
// Macro HACK_ALU_FLAGS_EXT_EN enables the adder carry/overflow flags; otherwise o_cy/o_ov are tied to 0.
module hack_alu_pipe #(
  parameter int DATA_WIDTH = 16,
  parameter int TAG_WIDTH = 4
) (
  input  logic                  i_Clk,
  input  logic                  i_Rst_n,
  input  logic                  i_InValid,
  output logic                  o_InReady,
  input  logic [DATA_WIDTH-1:0] i_Data1,
  input  logic [DATA_WIDTH-1:0] i_Data2,
  input  logic [5:0]            i_Ctrl,
  input  logic [TAG_WIDTH-1:0]  i_Tag,
  output logic                  o_OutValid,
  input  logic                  i_OutReady,
  output logic [DATA_WIDTH-1:0] o_Result,
  output logic                  o_zr,
  output logic                  o_ng,
  output logic                  o_cy,
  output logic                  o_ov,
  output logic [TAG_WIDTH-1:0]  o_Tag
);
  logic s1_valid, s1_f, s1_no, s2_free, s1_adv, accept;
  logic [DATA_WIDTH-1:0] x_z, y_z, x_in, y_in, s1_x, s1_y, add, pre, res;
  logic [TAG_WIDTH-1:0] s1_tag;
  assign s2_free = !o_OutValid || i_OutReady;
  assign s1_adv = s1_valid && s2_free;
  assign o_InReady = !s1_valid || s2_free;
  assign accept = i_InValid && o_InReady;
  assign x_z = i_Ctrl[5] ? '0 : i_Data1;
  assign x_in = i_Ctrl[4] ? ~x_z : x_z;
  assign y_z = i_Ctrl[3] ? '0 : i_Data2;
  assign y_in = i_Ctrl[2] ? ~y_z : y_z;
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      s1_valid <= 1'b0;
      s1_x <= '0;
      s1_y <= '0;
      s1_f <= 1'b0;
      s1_no <= 1'b0;
      s1_tag <= '0;
    end else begin
      s1_valid <= accept || (s1_valid && !s1_adv);
      if (accept) begin
        s1_x <= x_in;
        s1_y <= y_in;
        s1_f <= i_Ctrl[1];
        s1_no <= i_Ctrl[0];
        s1_tag <= i_Tag;
      end
    end
  end
`ifdef HACK_ALU_FLAGS_EXT_EN
  logic [DATA_WIDTH:0] sum;
  assign sum = {1'b0, s1_x} + {1'b0, s1_y};
  assign add = sum[DATA_WIDTH-1:0];
  // Carry and overflow describe the raw adder, before the optional output inversion.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_cy <= 1'b0;
      o_ov <= 1'b0;
    end else if (s1_adv) begin
      o_cy <= s1_f && sum[DATA_WIDTH];
      o_ov <= s1_f && (s1_x[DATA_WIDTH-1] == s1_y[DATA_WIDTH-1]) && (add[DATA_WIDTH-1] != s1_x[DATA_WIDTH-1]);
    end
  end
`else
  assign add = s1_x + s1_y;
  assign o_cy = 1'b0;
  assign o_ov = 1'b0;
`endif
  assign pre = s1_f ? add : (s1_x & s1_y);
  assign res = s1_no ? ~pre : pre;
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      o_OutValid <= 1'b0;
      o_Result <= '0;
      o_zr <= 1'b0;
      o_ng <= 1'b0;
      o_Tag <= '0;
    end else begin
      o_OutValid <= s1_adv || (o_OutValid && !i_OutReady);
      if (s1_adv) begin
        o_Result <= res;
        o_zr <= (res == '0);
        o_ng <= res[DATA_WIDTH-1];
        o_Tag <= s1_tag;
      end
    end
  end
endmodule

// File: tb/tb_hack_alu_pipe.sv
// tb_hack_alu_pipe: scoreboard bench for hack_alu_pipe using directed vectors with hand-computed results.
module tb_hack_alu_pipe;
  typedef struct packed {
    logic [15:0] r;
    logic zr;
    logic ng;
    logic cy;
    logic ov;
    logic [3:0] tag;
  } exp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [15:0] d1 = '0;
  logic [15:0] d2 = '0;
  logic [5:0] ctrl = '0;
  logic [3:0] tag_in = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [15:0] result;
  logic zr, ng, cy, ov;
  logic [3:0] tag_out;
  exp_t q[$];
  exp_t prev, cur;
  logic held = 1'b0;
  int compared = 0;
  int mismatched = 0;
  int accepted = 0;
  int stalls = 0;
  hack_alu_pipe #(.DATA_WIDTH(16), .TAG_WIDTH(4)) dut (
    .i_Clk(clk), .i_Rst_n(rst_n), .i_InValid(in_valid), .o_InReady(in_ready),
    .i_Data1(d1), .i_Data2(d2), .i_Ctrl(ctrl), .i_Tag(tag_in),
    .o_OutValid(out_valid), .i_OutReady(out_ready), .o_Result(result),
    .o_zr(zr), .o_ng(ng), .o_cy(cy), .o_ov(ov), .o_Tag(tag_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask
  assign cur = '{r: result, zr: zr, ng: ng, cy: cy, ov: ov, tag: tag_out};
  always @(negedge clk) begin
    if (rst_n && held) chk("hold_stable", 32'(cur), 32'(prev));
    if (rst_n && out_valid && out_ready) begin
      if (q.size() == 0) chk("unexpected_output", 32'(cur), 32'hFFFF_FFFF);
      else chk($sformatf("result_tag%0d", q[0].tag), 32'(cur), 32'(q.pop_front()));
    end
    held = rst_n && out_valid && !out_ready;
    prev = cur;
  end
  // Inputs change 1 time unit after a rising edge and are sampled on the falling edge.
  task automatic send(input logic [5:0] c, input logic [15:0] a, input logic [15:0] b, input logic [3:0] t,
                      input logic [15:0] r, input logic ecy, input logic eov);
    exp_t e;
    int n = 0;
    ctrl = c; d1 = a; d2 = b; tag_in = t; in_valid = 1'b1;
`ifdef HACK_ALU_FLAGS_EXT_EN
    e = '{r: r, zr: (r == 16'h0), ng: r[15], cy: ecy, ov: eov, tag: t};
`else
    e = '{r: r, zr: (r == 16'h0), ng: r[15], cy: 1'b0, ov: 1'b0, tag: t};
    if (ecy || eov) e.cy = 1'b0;
`endif
    forever begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(e);
        accepted++;
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      stalls++;
      if (++n > 50) begin
        chk("accept_timeout", 32'(n), 32'd0);
        in_valid = 1'b0;
        return;
      end
    end
  endtask
  task automatic drain();
    int n = 0;
    while (q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", 32'(q.size()), 32'd0);
  endtask
  initial begin
    #2;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_outputs", 32'(cur), 32'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);
    send(6'b010011, 16'd5, 16'd3, 4'd1, 16'd2, 1'b0, 1'b0);
    send(6'b000010, 16'h7FFF, 16'h0001, 4'd2, 16'h8000, 1'b0, 1'b1);
    send(6'b101010, 16'h1234, 16'h5678, 4'd3, 16'h0000, 1'b0, 1'b0);
    send(6'b111010, 16'h1234, 16'h5678, 4'd4, 16'hFFFF, 1'b0, 1'b0);
    send(6'b000000, 16'h0F0F, 16'h00FF, 4'd5, 16'h000F, 1'b0, 1'b0);
    send(6'b010101, 16'h0F00, 16'h00F0, 4'd6, 16'h0FF0, 1'b0, 1'b0);
    send(6'b000010, 16'hFFFF, 16'h0001, 4'd7, 16'h0000, 1'b1, 1'b0);
    send(6'b011111, 16'h0041, 16'h9999, 4'd8, 16'h0042, 1'b1, 1'b0);
    drain();
    stalls = 0;
    for (int i = 0; i < 8; i++) send(6'b000010, 16'(i), 16'(i), 4'(i), 16'(2 * i), 1'b0, 1'b0);
    chk("burst_no_stall", 32'(stalls), 32'd0);
    drain();
    out_ready = 1'b0;
    accepted = 0;
    fork
      for (int i = 0; i < 4; i++) send(6'b000010, 16'h0100, 16'(i), 4'(10 + i), 16'(16'h0100 + i), 1'b0, 1'b0);
      begin
        repeat (4) @(negedge clk);
        chk("bp_accepted", 32'(accepted), 32'd2);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    out_ready = 1'b0;
    send(6'b000010, 16'd1, 16'd1, 4'd1, 16'd2, 1'b0, 1'b0);
    send(6'b000010, 16'd2, 16'd2, 4'd2, 16'd4, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    chk("async_rst_valid", 32'(out_valid), 32'd0);
    chk("async_rst_outputs", 32'(cur), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send(6'b000010, 16'h0030, 16'h0009, 4'd9, 16'h0039, 1'b0, 1'b0);
    @(negedge clk);
    chk("lat_cycle1_invalid", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_cycle2_valid", 32'(out_valid), 32'd1);
    drain();
    repeat (3) @(negedge clk);
    chk("no_stale_output", 32'(out_valid), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
